// File: rtl/img_data_unpkt.sv
// img_data_unpkt: receive-side image depacketiser.
// Finds the frame head word and latches the {H,V} resolution that follows it.
// It then tags each pixel word with its x/y coordinate and line/frame markers.
// Malformed frames are dropped with an error strobe, and the block
// resynchronises on the next head word seen at the start of a packet.
module img_data_unpkt #(
    parameter logic [31:0] IMG_FRAME_HEAD = 32'hf05aa50f,
    parameter logic [15:0] MAX_H_PIXEL    = 16'd1920,
    parameter logic [15:0] MAX_V_PIXEL    = 16'd1080
) (
    input  logic        eth_rx_clk,
    input  logic        rst,
    input  logic        rx_enable,
    input  logic        udp_rec_en,
    input  logic [31:0] udp_rec_data,
    input  logic        udp_rec_pkt_done,
    output logic        img_frame_start,
    output logic [15:0] img_h_pixel,
    output logic [15:0] img_v_pixel,
    output logic        img_data_en,
    output logic [31:0] img_data,
    output logic [15:0] img_x,
    output logic [15:0] img_y,
    output logic        img_line_end,
    output logic        img_frame_done,
    output logic        err_pulse,
    output logic [1:0]  err_code
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RES,
        ST_DATA
    } state_t;

    localparam logic [1:0] ERR_RES     = 2'd1;
    localparam logic [1:0] ERR_ALIGN   = 2'd2;
    localparam logic [1:0] ERR_RESTART = 2'd3;

    state_t      state_q, state_d;
    logic        first_word_q, first_word_d;
    logic        line_closed_q, line_closed_d;
    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;
    logic [15:0] h_q, h_d;
    logic [15:0] v_q, v_d;

    logic        frame_start_q, frame_start_d;
    logic        data_en_q, data_en_d;
    logic [31:0] data_q, data_d;
    logic [15:0] img_x_q, img_x_d;
    logic [15:0] img_y_q, img_y_d;
    logic        line_end_q, line_end_d;
    logic        frame_done_q, frame_done_d;
    logic        err_pulse_q, err_pulse_d;
    logic [1:0]  err_code_q, err_code_d;

    logic [15:0] res_h;
    logic [15:0] res_v;
    logic        res_bad;
    logic        is_head;
    logic        last_col;
    logic        last_row;

    assign res_h    = udp_rec_data[31:16];
    assign res_v    = udp_rec_data[15:0];
    assign res_bad  = (res_h == '0) || (res_v == '0) ||
                      (res_h > MAX_H_PIXEL) || (res_v > MAX_V_PIXEL);
    assign is_head  = first_word_q && (udp_rec_data == IMG_FRAME_HEAD);
    assign last_col = (x_q == h_q - 16'd1);
    assign last_row = (y_q == v_q - 16'd1);

    // Next-state and registered-output computation for one received cycle.
    always_comb begin
        state_d       = state_q;
        line_closed_d = line_closed_q;
        x_d           = x_q;
        y_d           = y_q;
        h_d           = h_q;
        v_d           = v_q;
        frame_start_d = 1'b0;
        data_en_d     = 1'b0;
        data_d        = data_q;
        img_x_d       = img_x_q;
        img_y_d       = img_y_q;
        line_end_d    = 1'b0;
        frame_done_d  = 1'b0;
        err_pulse_d   = 1'b0;
        err_code_d    = err_code_q;

        // Packet boundary tracking is independent of rx_enable.
        if (udp_rec_pkt_done) begin
            first_word_d = 1'b1;
        end else if (udp_rec_en) begin
            first_word_d = 1'b0;
        end else begin
            first_word_d = first_word_q;
        end

        if (!rx_enable) begin
            state_d       = ST_IDLE;
            line_closed_d = 1'b0;
            x_d           = '0;
            y_d           = '0;
        end else begin
            if (udp_rec_en) begin
                case (state_q)
                    ST_IDLE: begin
                        if (is_head) begin
                            state_d = ST_RES;
                        end
                    end
                    ST_RES: begin
                        if (res_bad) begin
                            err_pulse_d = 1'b1;
                            err_code_d  = ERR_RES;
                            state_d     = ST_IDLE;
                        end else begin
                            h_d           = res_h;
                            v_d           = res_v;
                            frame_start_d = 1'b1;
                            x_d           = '0;
                            y_d           = '0;
                            line_closed_d = 1'b0;
                            state_d       = ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (is_head) begin
                            err_pulse_d = 1'b1;
                            err_code_d  = ERR_RESTART;
                            state_d     = ST_RES;
                        end else if (line_closed_q) begin
                            err_pulse_d = 1'b1;
                            err_code_d  = ERR_ALIGN;
                            state_d     = ST_IDLE;
                        end else begin
                            data_en_d = 1'b1;
                            data_d    = udp_rec_data;
                            img_x_d   = x_q;
                            img_y_d   = y_q;
                            if (last_col) begin
                                line_end_d    = 1'b1;
                                x_d           = '0;
                                y_d           = y_q + 16'd1;
                                line_closed_d = 1'b1;
                                if (last_row) begin
                                    frame_done_d = 1'b1;
                                    state_d      = ST_IDLE;
                                end
                            end else begin
                                x_d = x_q + 16'd1;
                            end
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end

            // Packet end is judged on the state left after this cycle's word.
            if (udp_rec_pkt_done) begin
                line_closed_d = 1'b0;
                if ((state_d == ST_RES) || ((state_d == ST_DATA) && (x_d != '0))) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = ERR_ALIGN;
                    state_d     = ST_IDLE;
                end
            end
        end
    end

    // State, counters and output registers with asynchronous reset.
    always_ff @(posedge eth_rx_clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            first_word_q  <= 1'b1;
            line_closed_q <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            h_q           <= '0;
            v_q           <= '0;
            frame_start_q <= 1'b0;
            data_en_q     <= 1'b0;
            data_q        <= '0;
            img_x_q       <= '0;
            img_y_q       <= '0;
            line_end_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            err_pulse_q   <= 1'b0;
            err_code_q    <= '0;
        end else begin
            state_q       <= state_d;
            first_word_q  <= first_word_d;
            line_closed_q <= line_closed_d;
            x_q           <= x_d;
            y_q           <= y_d;
            h_q           <= h_d;
            v_q           <= v_d;
            frame_start_q <= frame_start_d;
            data_en_q     <= data_en_d;
            data_q        <= data_d;
            img_x_q       <= img_x_d;
            img_y_q       <= img_y_d;
            line_end_q    <= line_end_d;
            frame_done_q  <= frame_done_d;
            err_pulse_q   <= err_pulse_d;
            err_code_q    <= err_code_d;
        end
    end

    assign img_frame_start = frame_start_q;
    assign img_h_pixel     = h_q;
    assign img_v_pixel     = v_q;
    assign img_data_en     = data_en_q;
    assign img_data        = data_q;
    assign img_x           = img_x_q;
    assign img_y           = img_y_q;
    assign img_line_end    = line_end_q;
    assign img_frame_done  = frame_done_q;
    assign err_pulse       = err_pulse_q;
    assign err_code        = err_code_q;

endmodule

// File: tb/tb_img_data_unpkt.sv
// Bench for img_data_unpkt: packet-level reference model with expected-event queues.
module tb_img_data_unpkt;

    localparam logic [31:0] HEAD = 32'hf05aa50f;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_enable;
    logic        udp_rec_en;
    logic [31:0] udp_rec_data;
    logic        udp_rec_pkt_done;
    logic        img_frame_start;
    logic [15:0] img_h_pixel;
    logic [15:0] img_v_pixel;
    logic        img_data_en;
    logic [31:0] img_data;
    logic [15:0] img_x;
    logic [15:0] img_y;
    logic        img_line_end;
    logic        img_frame_done;
    logic        err_pulse;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    img_data_unpkt #(
        .IMG_FRAME_HEAD (HEAD),
        .MAX_H_PIXEL    (16'd1920),
        .MAX_V_PIXEL    (16'd1080)
    ) dut (
        .eth_rx_clk       (clk),
        .rst              (rst),
        .rx_enable        (rx_enable),
        .udp_rec_en       (udp_rec_en),
        .udp_rec_data     (udp_rec_data),
        .udp_rec_pkt_done (udp_rec_pkt_done),
        .img_frame_start  (img_frame_start),
        .img_h_pixel      (img_h_pixel),
        .img_v_pixel      (img_v_pixel),
        .img_data_en      (img_data_en),
        .img_data         (img_data),
        .img_x            (img_x),
        .img_y            (img_y),
        .img_line_end     (img_line_end),
        .img_frame_done   (img_frame_done),
        .err_pulse        (err_pulse),
        .err_code         (err_code)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [15:0] x;
        logic [15:0] y;
        logic        le;
        logic        fd;
    } beat_t;

    beat_t       exp_beats[$];
    logic [31:0] exp_starts[$];
    logic [1:0]  exp_errs[$];
    logic [31:0] pkt_q[$];

    int unsigned total = 0;
    int unsigned bad   = 0;

    task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor: every event must match the head of its expectation queue.
    always @(negedge clk) begin : monitor
        beat_t       e;
        logic [31:0] s;
        logic [1:0]  c;
        if (!rst) begin
            if (img_data_en) begin
                check("beat_expected", 66'(exp_beats.size() != 0), 66'd1);
                if (exp_beats.size() != 0) begin
                    e = exp_beats.pop_front();
                    check("beat", {img_data, img_x, img_y, img_line_end, img_frame_done}, e);
                end
            end else if (img_line_end || img_frame_done) begin
                check("marker_without_data", 66'({img_line_end, img_frame_done}), 66'd0);
            end
            if (img_frame_start) begin
                check("start_expected", 66'(exp_starts.size() != 0), 66'd1);
                if (exp_starts.size() != 0) begin
                    s = exp_starts.pop_front();
                    check("start_res", 66'({img_h_pixel, img_v_pixel}), 66'(s));
                end
            end
            if (err_pulse) begin
                check("err_expected", 66'(exp_errs.size() != 0), 66'd1);
                if (exp_errs.size() != 0) begin
                    c = exp_errs.pop_front();
                    check("err_code", 66'(err_code), 66'(c));
                end
            end
        end
    end

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input logic done);
        udp_rec_en       = 1'b1;
        udp_rec_data     = w;
        udp_rec_pkt_done = done;
        @(posedge clk);
        #1;
        udp_rec_en       = 1'b0;
        udp_rec_pkt_done = 1'b0;
        udp_rec_data     = $urandom();
    endtask

    task automatic send_pkt(input bit gaps);
        bit sep;
        sep = gaps && ($urandom_range(0, 1) == 1);
        for (int unsigned i = 0; i < pkt_q.size(); i++) begin
            send_word(pkt_q[i], (i == pkt_q.size() - 1) && !sep);
            if (gaps) idle($urandom_range(0, 2));
        end
        if (sep) begin
            udp_rec_pkt_done = 1'b1;
            @(posedge clk);
            #1;
            udp_rec_pkt_done = 1'b0;
        end
        pkt_q.delete();
        if (gaps) idle($urandom_range(0, 3));
    endtask

    function automatic logic [31:0] rand_pix();
        logic [31:0] w;
        do w = $urandom(); while (w == HEAD);
        return w;
    endfunction

    function automatic void push_beat(input logic [31:0] d, input int unsigned x,
                                      input int unsigned y, input int unsigned h,
                                      input int unsigned v);
        beat_t b;
        b.d  = d;
        b.x  = x[15:0];
        b.y  = y[15:0];
        b.le = (x == h - 1);
        b.fd = (x == h - 1) && (y == v - 1);
        exp_beats.push_back(b);
    endfunction

    // fault: 0 clean, 1 line fline one word short, 2 line fline one word long,
    // 3 abandoned before line fline (caller must send the restarting frame next)
    task automatic run_frame(input int unsigned h, input int unsigned v, input int unsigned fault,
                             input int unsigned fline, input bit gaps);
        int unsigned n;
        logic [31:0] p;
        exp_starts.push_back({h[15:0], v[15:0]});
        pkt_q.push_back(HEAD);
        pkt_q.push_back({h[15:0], v[15:0]});
        for (int unsigned y = 0; y < v; y++) begin
            if (fault == 3 && y == fline) begin
                exp_errs.push_back(2'd3);
                return;
            end
            n = h;
            if (fault == 1 && y == fline) n = h - 1;
            if (fault == 2 && y == fline) n = h + 1;
            for (int unsigned x = 0; x < n; x++) begin
                p = rand_pix();
                pkt_q.push_back(p);
                if (x < h) push_beat(p, x, y, h, v);
            end
            if ((fault == 1 || fault == 2) && y == fline) exp_errs.push_back(2'd2);
            send_pkt(gaps);
            if ((fault == 1 || fault == 2) && y == fline) return;
        end
    endtask

    task automatic bad_res(input logic [31:0] res, input bit gaps);
        exp_errs.push_back(2'd1);
        pkt_q.push_back(HEAD);
        pkt_q.push_back(res);
        pkt_q.push_back(rand_pix());
        pkt_q.push_back(rand_pix());
        send_pkt(gaps);
    endtask

    task automatic drain(input string tag);
        idle(4);
        check({tag, "_beats_left"},  66'(exp_beats.size()),  66'd0);
        check({tag, "_starts_left"}, 66'(exp_starts.size()), 66'd0);
        check({tag, "_errs_left"},   66'(exp_errs.size()),   66'd0);
        exp_beats.delete();
        exp_starts.delete();
        exp_errs.delete();
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin : stim
        logic [31:0] p;
        int unsigned h, v, f, fl, sel;

        rst              = 1'b1;
        rx_enable        = 1'b1;
        udp_rec_en       = 1'b0;
        udp_rec_pkt_done = 1'b0;
        udp_rec_data     = '0;
        idle(3);
        check("rst_data", 66'({img_data, img_x, img_y}), 66'd0);
        check("rst_ctl", 66'({img_frame_start, img_data_en, img_line_end, img_frame_done,
                              err_pulse, err_code, img_h_pixel, img_v_pixel}), 66'd0);
        rst = 1'b0;
        idle(2);

        // Nominal 4x2 frame
        run_frame(4, 2, 0, 0, 1'b0);
        drain("nominal");

        // Bad resolutions, then a good frame
        bad_res(32'h00000002, 1'b0);
        bad_res(32'h07810010, 1'b0);
        bad_res({16'd5, 16'd0}, 1'b1);
        bad_res({16'd1, 16'd1081}, 1'b1);
        run_frame(4, 2, 0, 0, 1'b0);
        drain("bad_res");

        // Short second line, long second line, early restart
        run_frame(4, 2, 1, 1, 1'b0);
        drain("short_pkt");
        run_frame(4, 3, 2, 1, 1'b0);
        drain("long_pkt");
        run_frame(4, 3, 3, 1, 1'b0);
        run_frame(4, 3, 0, 0, 1'b0);
        drain("restart");

        // Resolution limits
        run_frame(1920, 1, 0, 0, 1'b0);
        drain("max_h");
        run_frame(1, 1080, 0, 0, 1'b0);
        drain("max_v");

        // rx_enable dropped mid-line, head as non-first word afterwards
        exp_starts.push_back({16'd4, 16'd2});
        send_word(HEAD, 1'b0);
        send_word({16'd4, 16'd2}, 1'b0);
        for (int unsigned x = 0; x < 2; x++) begin
            p = rand_pix();
            push_beat(p, x, 0, 4, 2);
            send_word(p, 1'b0);
        end
        rx_enable = 1'b0;
        idle(1);
        send_word(rand_pix(), 1'b0);
        send_word(rand_pix(), 1'b1);
        idle(2);
        check("disabled_data_en", 66'(img_data_en), 66'd0);
        check("disabled_res_hold", 66'({img_h_pixel, img_v_pixel}), 66'({16'd4, 16'd2}));
        rx_enable = 1'b1;
        idle(1);
        pkt_q.push_back(rand_pix());
        pkt_q.push_back(HEAD);
        pkt_q.push_back({16'd4, 16'd2});
        pkt_q.push_back(rand_pix());
        send_pkt(1'b0);
        drain("rx_enable");
        run_frame(3, 2, 0, 0, 1'b1);
        drain("after_enable");

        // Asynchronous reset mid-frame
        exp_starts.push_back({16'd4, 16'd2});
        send_word(HEAD, 1'b0);
        send_word({16'd4, 16'd2}, 1'b0);
        for (int unsigned x = 0; x < 2; x++) begin
            p = rand_pix();
            push_beat(p, x, 0, 4, 2);
            send_word(p, 1'b0);
        end
        send_word(rand_pix(), 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_data", 66'({img_data, img_x, img_y}), 66'd0);
        check("midrst_ctl", 66'({img_frame_start, img_data_en, img_line_end, img_frame_done,
                                 err_pulse, err_code, img_h_pixel, img_v_pixel}), 66'd0);
        idle(2);
        rst = 1'b0;
        idle(1);
        drain("mid_reset");
        run_frame(2, 2, 0, 0, 1'b1);
        drain("after_reset");

        // Randomized frames with injected faults
        for (int unsigned it = 0; it < 40; it++) begin
            h = $urandom_range(1, 6);
            v = $urandom_range(1, 4);
            f = $urandom_range(0, 4);
            fl = 0;
            if (f == 1 && h < 2) f = 0;
            if ((f == 2 || f == 3) && v < 2) f = 0;
            if (f == 1) fl = $urandom_range(0, v - 1);
            if (f == 2) fl = $urandom_range(0, v - 2);
            if (f == 3) fl = $urandom_range(1, v - 1);
            if (f == 4) begin
                sel = $urandom_range(0, 3);
                case (sel)
                    0: bad_res({16'd0, v[15:0]}, 1'b1);
                    1: bad_res({h[15:0], 16'd0}, 1'b1);
                    2: bad_res({16'(1921 + $urandom_range(0, 100)), v[15:0]}, 1'b1);
                    default: bad_res({h[15:0], 16'(1081 + $urandom_range(0, 100))}, 1'b1);
                endcase
            end else begin
                run_frame(h, v, f, fl, 1'b1);
                if (f == 3) run_frame($urandom_range(1, 6), $urandom_range(1, 4), 0, 0, 1'b1);
            end
            drain("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/img_data_unpkt.md
Name: img_data_unpkt

Overview:
- Receive-side counterpart of the UDP image packetiser; sits between the UDP receive engine and the frame-buffer write path on the eth_rx_clk domain.
- Frames arrive as follows:
  - First packet: frame head word, resolution word {H[15:0],V[15:0]}, then H pixel words.
  - Each following packet: exactly one line of H words.
- The block finds the frame head and latches the resolution. It emits pixel words tagged with x/y coordinates, line/frame markers and error pulses, and drops any malformed frame and resynchronises.

Parameters:
- IMG_FRAME_HEAD, 32'hf05aa50f, frame-start marker word.
- MAX_H_PIXEL, 16'd1920, largest accepted horizontal resolution.
- MAX_V_PIXEL, 16'd1080, largest accepted vertical resolution.

Ports:
- eth_rx_clk  in  1  Ethernet receive clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- rx_enable  in  1  1 = accept frames; 0 = force IDLE and suppress all outputs.
- udp_rec_en  in  1  udp_rec_data valid this cycle.
- udp_rec_data  in  32  received payload word.
- udp_rec_pkt_done  in  1  one-cycle pulse marking end of the current UDP packet.
- img_frame_start  out  1  pulse; new frame accepted.
- img_h_pixel  out  16  latched horizontal resolution.
- img_v_pixel  out  16  latched vertical resolution.
- img_data_en  out  1  img_data valid.
- img_data  out  32  pixel word.
- img_x  out  16  column of the current img_data.
- img_y  out  16  line of the current img_data.
- img_line_end  out  1  pulse with the last word of a line.
- img_frame_done  out  1  pulse with the last word of a frame.
- err_pulse  out  1  one-cycle error strobe.
- err_code  out  2  error cause, valid with err_pulse: 1 = bad resolution, 2 = packet/line misalignment, 3 = frame restarted early.

Behaviour:
- Reset: all outputs 0; state IDLE; internal counters 0.
- Internal first_word flag:
  - Set by reset and by udp_rec_pkt_done.
  - Cleared by any udp_rec_en.
- Simultaneous udp_rec_en and udp_rec_pkt_done in one cycle: the word is processed first, then the packet end is evaluated.
- IDLE:
  - A word with first_word=1 and data==IMG_FRAME_HEAD → RES.
  - All other words are ignored; no error is raised.
- RES: on the next valid word:
  - Take H=data[31:16], V=data[15:0].
  - If H==0, V==0, H>MAX_H_PIXEL or V>MAX_V_PIXEL → err_code 1, go IDLE.
  - Otherwise latch img_h_pixel/img_v_pixel, pulse img_frame_start next cycle, clear x/y counters, go DATA.
  - udp_rec_pkt_done while in RES → err_code 2, go IDLE.
- DATA, per valid word:
  - Outputs are registered one cycle later: img_data_en=1, img_data=word, img_x=x, img_y=y.
  - x increments after each word.
  - When x==H-1: img_line_end pulses with that word, x returns to 0, y increments, and line_closed is set.
  - When also y==V-1: img_frame_done pulses with that word and the block goes IDLE.
- Line/packet alignment:
  - udp_rec_pkt_done clears line_closed.
  - A word arriving while line_closed=1 (line longer than packet allows) → err_code 2, go IDLE; the word is not output.
  - udp_rec_pkt_done with x!=0 (short packet) → err_code 2, go IDLE.
- Resync:
  - In DATA, a word with first_word=1 and data==IMG_FRAME_HEAD, arriving before frame done, → err_code 3, go RES; that word is not output.
  - A pixel equal to IMG_FRAME_HEAD at line start is therefore treated as a head. This is an accepted limitation.
- Dropped frames: img_frame_done never fires; downstream discards the partial frame on the next img_frame_start.
- rx_enable=0:
  - Takes effect synchronously; state goes IDLE.
  - Pulses and img_data_en are 0 from the next cycle.
  - img_h_pixel and img_v_pixel keep their values.
- Pulses (img_frame_start, img_line_end, img_frame_done, err_pulse) are exactly one cycle wide.
- err_code holds its value until the next err_pulse.
- No internal buffering: the block accepts a word every cycle and never back-pressures.

Test Plan:
- Nominal frame, H=4, V=2: send packet [f05aa50f, 00040002, d0..d3], then packet [d4..d7] → img_frame_start once; 8 img_data_en beats with x=0..3, y=0/1; img_line_end on d3 and d7; img_frame_done on d7; err_pulse never.
- Bad resolution: [f05aa50f, 00000002, ...] and [f05aa50f, 07810010, ...] → err_code 1 each time; no img_data_en; the following valid frame is received normally.
- Short packet: H=4, second packet carries 3 words then udp_rec_pkt_done → err_code 2 at packet end; 3 words output for y=1; no img_frame_done.
- Long packet: H=4, second packet carries 5 words → 5th word not output; err_code 2; state IDLE.
- Early restart: H=4, V=3; after line 0, a new head packet [f05aa50f, 00040003, ...] → err_code 3; img_frame_start for the new frame; counters restart at x=0, y=0.
- Control and reset: rx_enable deasserted mid-line, then head word sent as non-first word of a packet → no outputs and no error; assert rst mid-frame → all outputs 0 immediately; next head resyncs.
